// File: rtl/rect_calc.sv
// -----------------------------------------------------------------------------
// rect_calc : parametrised rectangle-measure unit.
//
// Captures two unsigned side lengths on an active-low data-available handshake
// and computes either the perimeter (single-cycle adder) or the area (iterative
// shift-add multiplier, one partial product per cycle).
//
// Ports
//   clock     in   1    system clock, rising edge
//   _reset    in   1    asynchronous active-low reset
//   _dav      in   1    data available from producer, active low
//   a         in   W    side 1, unsigned
//   b         in   W    side 2, unsigned
//   mode      in   1    0 = perimeter, 1 = area (sampled with a and b)
//   rfd       out  1    ready for data to producer, active high
//   result    out  2W   last computed value, held until the next done
//   done      out  1    one-cycle pulse when result updates
//   zero      out  1    last operation had a side equal to zero
//   op_count  out  CW   completed operations, wraps modulo 2^CW
// -----------------------------------------------------------------------------
module rect_calc #(
    parameter int W  = 4,
    parameter int CW = 8
) (
    input  logic              clock,
    input  logic              _reset,
    input  logic              _dav,
    input  logic [W-1:0]      a,
    input  logic [W-1:0]      b,
    input  logic              mode,
    output logic              rfd,
    output logic [2*W-1:0]    result,
    output logic              done,
    output logic              zero,
    output logic [CW-1:0]     op_count
);

    // Iteration counter must reach W: the area pass spends W cycles adding
    // partial products plus one cycle on which it sees the count exhausted.
    localparam int IW = $clog2(W + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIN  = 2'd2,
        ST_WAIT = 2'd3
    } state_t;

    state_t              state_r;
    logic [W-1:0]        a_r;
    logic [W-1:0]        b_r;
    logic                mode_r;
    logic [2*W-1:0]      acc_r;
    logic [IW-1:0]       iter_r;
    logic                rfd_r;
    logic [2*W-1:0]      result_r;
    logic                done_r;
    logic                zero_r;
    logic [CW-1:0]       op_count_r;

    logic                mul_bit_s;
    logic [2*W-1:0]      partial_s;
    logic                iter_end_s;

    // Perimeter: (W+1)-bit sum doubled, zero-extended to the result width.
    function automatic logic [2*W-1:0] perimeter_of(input logic [W-1:0] x,
                                                    input logic [W-1:0] y);
        logic [W:0]     sum;
        logic [2*W-1:0] p;
        sum        = {1'b0, x} + {1'b0, y};
        p          = '0;
        p[W+1:1]   = sum;
        return p;
    endfunction

    // Multiplicand shifted to the weight of the current multiplier bit.
    function automatic logic [2*W-1:0] shifted_of(input logic [W-1:0]  x,
                                                  input logic [IW-1:0] sh);
        logic [2*W-1:0] ext;
        ext = {{W{1'b0}}, x};
        return ext << sh;
    endfunction

    // Select the current multiplier bit and partial product for the area pass.
    always_comb begin
        logic [W-1:0] b_shift;
        b_shift    = b_r >> iter_r;
        mul_bit_s  = b_shift[0];
        partial_s  = shifted_of(a_r, iter_r);
        if (iter_r == IW'(W)) begin
            iter_end_s = 1'b1;
        end else begin
            iter_end_s = 1'b0;
        end
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clock or negedge _reset) begin
        if (!_reset) begin
            state_r    <= ST_IDLE;
            a_r        <= '0;
            b_r        <= '0;
            mode_r     <= 1'b0;
            acc_r      <= '0;
            iter_r     <= '0;
            rfd_r      <= 1'b1;
            result_r   <= '0;
            done_r     <= 1'b0;
            zero_r     <= 1'b0;
            op_count_r <= '0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    rfd_r <= 1'b1;
                    if (!_dav) begin
                        a_r     <= a;
                        b_r     <= b;
                        mode_r  <= mode;
                        acc_r   <= '0;
                        iter_r  <= '0;
                        rfd_r   <= 1'b0;
                        state_r <= ST_CALC;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    if (!mode_r) begin
                        acc_r   <= perimeter_of(a_r, b_r);
                        state_r <= ST_FIN;
                    end else if (iter_end_s) begin
                        state_r <= ST_FIN;
                    end else begin
                        if (mul_bit_s) begin
                            acc_r <= acc_r + partial_s;
                        end else begin
                            acc_r <= acc_r;
                        end
                        iter_r  <= iter_r + IW'(1);
                        state_r <= ST_CALC;
                    end
                end
                ST_FIN: begin
                    result_r   <= acc_r;
                    zero_r     <= (a_r == '0) || (b_r == '0);
                    done_r     <= 1'b1;
                    op_count_r <= op_count_r + CW'(1);
                    state_r    <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Only a released _dav re-arms; a held-low _dav never retriggers.
                    if (_dav) begin
                        rfd_r   <= 1'b1;
                        state_r <= ST_IDLE;
                    end else begin
                        rfd_r   <= 1'b0;
                        state_r <= ST_WAIT;
                    end
                end
                default: begin
                    rfd_r   <= 1'b1;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign rfd      = rfd_r;
    assign result   = result_r;
    assign done     = done_r;
    assign zero     = zero_r;
    assign op_count = op_count_r;

endmodule

// File: doc/rect_calc.md
Name: rect_calc

Overview:
- Parametrised rectangle-measure unit; successor to the fixed 4-bit perimeter calculator.
- Side width is generic, and a mode input selects perimeter (single-cycle adder) or area (iterative shift-add multiplier, W cycles).
- Keeps the same input handshake: active-low _dav from the producer, rfd back to it.
- Adds a done strobe, a zero-side flag and a wrapping operation counter. It sits between a side-length producer and downstream display/accumulation logic.

Parameters:
- W, 4, side width in bits; legal W >= 2. Result width is 2W.
- CW, 8, width of the completed-operation counter.

Ports:
- clock  in  1  system clock, rising edge.
- _reset  in  1  asynchronous, active-low reset.
- _dav  in  1  data-available from producer, active low.
- a  in  W  side 1, unsigned.
- b  in  W  side 2, unsigned.
- mode  in  1  0 = perimeter, 1 = area; sampled with a and b.
- rfd  out  1  ready-for-data to producer, active high.
- result  out  2W  last computed value, held until the next done.
- done  out  1  one-cycle pulse when result updates.
- zero  out  1  last operation had a==0 or b==0; updates with result.
- op_count  out  CW  number of completed operations, wraps modulo 2^CW.

Behaviour:
- Reset (asynchronous on _reset low, held while low): state IDLE, rfd=1, result=0, done=0, zero=0, op_count=0, internal registers cleared.
- Reset mid-operation: the calculation is abandoned and no done is issued. After release, the block waits in IDLE for a fresh _dav falling level.
- All state changes occur on the rising edge of clock. done defaults to 0 on every edge unless set in FIN.
- States:
  - IDLE: rfd=1. At an edge with _dav==0, capture a, b and mode into internal registers, set rfd<=0, clear the accumulator and iteration counter, go to CALC. With _dav==1, stay in IDLE.
  - CALC, perimeter mode: on one edge, acc <= (a_r + b_r) << 1, computed as W+1-bit sum then shifted, zero-extended to 2W. Go to FIN.
  - CALC, area mode: W edges, i = 0..W-1. If b_r[i]==1, acc <= acc + (a_r << i), 2W-bit add. Go to FIN after i == W-1.
  - FIN: on one edge, result<=acc, zero<=(a_r==0 || b_r==0), done<=1, op_count<=op_count+1 (wraps from 2^CW-1 to 0). Go to WAIT.
  - WAIT: rfd stays 0. At an edge with _dav==1, set rfd<=1 and go to IDLE. While _dav stays 0, remain in WAIT; no retrigger occurs.
- Latency, counting edge 0 as the capture edge:
  - Perimeter: result and done visible after edge 2.
  - Area: result and done visible after edge W+2.
- If _dav has already returned high before WAIT, rfd rises one edge after entering WAIT.
- No overflow is possible: max perimeter 4(2^W-1) and max area (2^W-1)^2 both fit in 2W bits for W>=2.
- a, b and mode changes after the capture edge are ignored. rfd low means the inputs are don't-care.
- A zero side still runs the full latency for its mode and gives result 0 with zero=1.
- The producer must not lower _dav again until it sees rfd high. A _dav low seen in IDLE one edge after rfd rises is a legal back-to-back start.

Test Plan:
- W=4, perimeter, a=3, b=5, _dav low: rfd falls after edge 0; result=16 and done=1 for exactly one cycle after edge 2; op_count=1; raise _dav, rfd=1 one edge later.
- W=4, area, a=15, b=15: result=225 after edge 6 (W+2), done pulses once, zero=0. Then a=7, b=0 area: result=0, zero=1 after edge 6.
- W=8, a=255, b=255: area gives result=65025 after edge 10; perimeter gives result=1020 after edge 2.
- Hold _dav low through WAIT for 10 cycles: rfd stays 0, no second done, op_count unchanged. Releasing _dav restores rfd=1 and the next _dav low starts a new operation.
- Assert _reset low at edge 3 of a W=8 area operation: rfd=1, result=0, op_count=0 immediately, without waiting for a clock edge, and no done. The next perimeter a=1, b=1 after release gives result=4.
- CW=2: run 5 perimeter operations back-to-back; op_count reads 1, 2, 3, 0, 1. Change a and b during CALC: result reflects only the captured values.
